// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_pkg
//  Description : Shared constants for the multiply/divide unit and the
//                decoder: HILOCtrl encodings, operation latencies and the
//                AO-mux select code that picks the MDU read data.
//  Revision    : 1.0 - initial release
// ============================================================================
package mdu_pkg;

  // HILOCtrl operation encodings driven by decode
  localparam logic [3:0] mduNone  = 4'd0;
  localparam logic [3:0] mduMult  = 4'd1;
  localparam logic [3:0] mduMultu = 4'd2;
  localparam logic [3:0] mduDiv   = 4'd3;
  localparam logic [3:0] mduDivu  = 4'd4;
  localparam logic [3:0] mduMfhi  = 4'd5;
  localparam logic [3:0] mduMflo  = 4'd6;
  localparam logic [3:0] mduMthi  = 4'd7;
  localparam logic [3:0] mduMtlo  = 4'd8;

  // Busy duration, in cycles, of a launched operation
  localparam logic [3:0] c_lat_mult = 4'd5;
  localparam logic [3:0] c_lat_div  = 4'd10;

  // AO-mux select code that routes MDUOut onto the AO bus
  localparam logic [1:0] aoMDU = 2'd2;

  // True for the four operations that a Start pulse may launch
  function automatic logic is_arith(input logic [3:0] op);
    return (op == mduMult) || (op == mduMultu) ||
           (op == mduDiv)  || (op == mduDivu);
  endfunction

  // Busy duration for a launched operation (multiplies are shorter)
  function automatic logic [3:0] op_latency(input logic [3:0] op);
    return ((op == mduDiv) || (op == mduDivu)) ? c_lat_div : c_lat_mult;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_calc.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_calc
//  Description : Purely combinational arithmetic core of the MDU. Produces
//                the 64-bit {hi,lo} result of mult/multu/div/divu. A divide
//                by zero, or any non-arithmetic op, passes the current HI/LO
//                through so the register file contents stay unchanged.
//  Revision    : 1.0 - initial release
// ============================================================================
module mdu_calc
  import mdu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi_in,
  input  logic [31:0] lo_in,
  input  logic [3:0]  op,
  output logic [63:0] res
);

  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic        w_b_zero;
  logic [31:0] w_b_safe;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;
  logic [31:0] w_q_s;
  logic [31:0] w_r_s;
  logic [31:0] w_q_u;
  logic [31:0] w_r_u;

  // Low 64 bits of the product of sign-extended operands equal the signed product
  assign w_prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign w_prod_u = {32'd0, a} * {32'd0, b};

  // Divisor forced to 1 on zero so the dividers never see a zero operand
  assign w_b_zero = (b == 32'd0);
  assign w_b_safe = w_b_zero ? 32'd1 : b;

  // Signed divide via magnitudes: quotient truncates toward zero, remainder
  // takes the sign of the dividend. -2^31 / -1 wraps to -2^31 with remainder 0.
  assign w_a_mag = a[31] ? (32'd0 - a) : a;
  assign w_b_mag = w_b_safe[31] ? (32'd0 - w_b_safe) : w_b_safe;
  assign w_q_mag = w_a_mag / w_b_mag;
  assign w_r_mag = w_a_mag % w_b_mag;
  assign w_q_s   = (a[31] ^ w_b_safe[31]) ? (32'd0 - w_q_mag) : w_q_mag;
  assign w_r_s   = a[31] ? (32'd0 - w_r_mag) : w_r_mag;

  assign w_q_u = a / w_b_safe;
  assign w_r_u = a % w_b_safe;

  // Select the result for the requested operation
  always_comb begin
    res = {hi_in, lo_in};
    case (op)
      mduMult:  res = w_prod_s;
      mduMultu: res = w_prod_u;
      mduDiv:   res = w_b_zero ? {hi_in, lo_in} : {w_r_s, w_q_s};
      mduDivu:  res = w_b_zero ? {hi_in, lo_in} : {w_r_u, w_q_u};
      default:  res = {hi_in, lo_in};
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mdu.sv
`default_nettype none
// ============================================================================
//  Module      : mdu
//  Description : Multiply/divide unit holding the HI/LO registers. Launches
//                mult/multu/div/divu on a Start pulse, serves mfhi/mflo
//                reads combinationally and accepts mthi/mtlo writes.
//                Build option MDU_LATENCY_EN: when defined, a launched
//                operation keeps Busy high for 5 (mult) or 10 (div) cycles
//                before committing to HI/LO; when undefined the result is
//                written at the launch edge and Busy is always 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module mdu
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [3:0]  HILOCtrl,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] MDUOut
);

  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [63:0] w_res;
  logic        w_launch;
  logic        w_mthi;
  logic        w_mtlo;

  mdu_calc u_calc (
    .a     (A),
    .b     (B),
    .hi_in (r_hi),
    .lo_in (r_lo),
    .op    (HILOCtrl),
    .res   (w_res)
  );

  // Start with a non-arithmetic op does nothing; moves to HI/LO never carry Start
  assign w_launch = Start && is_arith(HILOCtrl);
  assign w_mthi   = !Start && (HILOCtrl == mduMthi);
  assign w_mtlo   = !Start && (HILOCtrl == mduMtlo);

`ifdef MDU_LATENCY_EN
  logic [31:0] r_hi_t;
  logic [31:0] r_lo_t;
  logic [3:0]  r_cnt;
  logic        r_busy;

  // HI/LO and pending result; while busy every other request is ignored
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hi   <= 32'd0;
      r_lo   <= 32'd0;
      r_hi_t <= 32'd0;
      r_lo_t <= 32'd0;
      r_cnt  <= 4'd0;
      r_busy <= 1'b0;
    end else if (r_busy) begin
      r_cnt <= r_cnt - 4'd1;
      if (r_cnt == 4'd1) begin
        r_hi   <= r_hi_t;
        r_lo   <= r_lo_t;
        r_busy <= 1'b0;
      end
    end else if (w_launch) begin
      r_hi_t <= w_res[63:32];
      r_lo_t <= w_res[31:0];
      r_cnt  <= op_latency(HILOCtrl);
      r_busy <= 1'b1;
    end else if (w_mthi) begin
      r_hi <= A;
    end else if (w_mtlo) begin
      r_lo <= A;
    end
  end

  assign Busy = r_busy;
`else
  // HI/LO update: launched results land at the launch edge itself
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hi <= 32'd0;
      r_lo <= 32'd0;
    end else if (w_launch) begin
      r_hi <= w_res[63:32];
      r_lo <= w_res[31:0];
    end else if (w_mthi) begin
      r_hi <= A;
    end else if (w_mtlo) begin
      r_lo <= A;
    end
  end

  assign Busy = 1'b0;
`endif

  // Read port shows only the architectural HI/LO, never a pending result
  always_comb begin
    MDUOut = 32'd0;
    case (HILOCtrl)
      mduMfhi: MDUOut = r_hi;
      mduMflo: MDUOut = r_lo;
      default: MDUOut = 32'd0;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mdu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mdu
//  Description : Self-checking bench for mdu. Expected {HI,LO} results are
//                queued when an operation is launched and popped when it
//                completes, then compared with mfhi/mflo reads.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu;
  import mdu_pkg::*;

`ifdef MDU_LATENCY_EN
  localparam int LAT_MULT = 5;
  localparam int LAT_DIV  = 10;
`else
  localparam int LAT_MULT = 0;
  localparam int LAT_DIV  = 0;
`endif

  logic        clk;
  logic        reset;
  logic        Start;
  logic [3:0]  HILOCtrl;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic [31:0] MDUOut;

  int total;
  int bad;

  logic [63:0] sb[$];
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  mdu dut (
    .clk      (clk),
    .reset    (reset),
    .Start    (Start),
    .HILOCtrl (HILOCtrl),
    .A        (A),
    .B        (B),
    .Busy     (Busy),
    .MDUOut   (MDUOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference result for an arithmetic op given the model HI/LO
  function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sbv;
    int     ia, ib;
    logic [63:0] r;
    r = {m_hi, m_lo};
    case (op)
      mduMult: begin
        sa = longint'($signed(a));
        sbv = longint'($signed(b));
        r = 64'(sa * sbv);
      end
      mduMultu: r = {32'd0, a} * {32'd0, b};
      mduDiv: if (b != 32'd0) begin
        ia = a;
        ib = b;
        r = {32'(ia % ib), 32'(ia / ib)};
      end
      mduDivu: if (b != 32'd0) r = {a % b, a / b};
      default: r = {m_hi, m_lo};
    endcase
    return r;
  endfunction

  // Launch one op, queue its expected result, count Busy cycles until done
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int n, output bit to);
    @(negedge clk);
    Start = 1'b1; HILOCtrl = op; A = a; B = b;
    sb.push_back(model(op, a, b));
    @(negedge clk);
    Start = 1'b0; HILOCtrl = mduNone;
    n = 0;
    while (Busy === 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    to = (Busy !== 1'b0);
  endtask

  task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
    @(negedge clk);
    Start = 1'b0;
    HILOCtrl = mduMfhi; #1 h = MDUOut;
    HILOCtrl = mduMflo; #1 l = MDUOut;
    HILOCtrl = mduNone;
  endtask

  task automatic write_hl(input logic [3:0] op, input logic [31:0] v);
    @(negedge clk);
    Start = 1'b0; HILOCtrl = op; A = v;
    @(negedge clk);
    HILOCtrl = mduNone;
    if (op == mduMthi) m_hi = v; else m_lo = v;
  endtask

  task automatic test_reset();
    reset = 1'b1; Start = 1'b0; HILOCtrl = mduNone; A = '0; B = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    HILOCtrl = mduMfhi; #1;
    total++; if (MDUOut !== 32'd0) begin bad++; $display("FAIL reset_hi: got %h want 0", MDUOut); end
    HILOCtrl = mduMflo; #1;
    total++; if (MDUOut !== 32'd0) begin bad++; $display("FAIL reset_lo: got %h want 0", MDUOut); end
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", Busy); end
    HILOCtrl = mduNone;
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
  endtask

  task automatic test_mthi_mtlo();
    logic [31:0] h, l;
    write_hl(mduMthi, 32'hCAFEBABE);
    write_hl(mduMtlo, 32'h0BADF00D);
    read_hilo(h, l);
    total++; if (h !== 32'hCAFEBABE) begin bad++; $display("FAIL mthi: got %h want cafebabe", h); end
    total++; if (l !== 32'h0BADF00D) begin bad++; $display("FAIL mtlo: got %h want 0badf00d", l); end
    #1;
    total++; if (MDUOut !== 32'd0) begin bad++; $display("FAIL mduout_none: got %h want 0", MDUOut); end
  endtask

  task automatic test_arith(input string nm, input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] wh, input logic [31:0] wl,
                            input int lat);
    logic [63:0] e;
    logic [31:0] h, l;
    int n;
    bit to;
    run_op(op, a, b, n, to);
    e = sb.pop_front();
    m_hi = e[63:32]; m_lo = e[31:0];
    total++; if (to || n != lat) begin bad++; $display("FAIL %s_busy: got %0d cycles want %0d", nm, n, lat); end
    read_hilo(h, l);
    total++; if (h !== wh) begin bad++; $display("FAIL %s_hi: got %h want %h", nm, h, wh); end
    total++; if (l !== wl) begin bad++; $display("FAIL %s_lo: got %h want %h", nm, l, wl); end
  endtask

  task automatic test_div_zero();
    write_hl(mduMthi, 32'h12345678);
    write_hl(mduMtlo, 32'h55AA55AA);
    test_arith("div0", mduDiv, 32'd5, 32'd0, 32'h12345678, 32'h55AA55AA, LAT_DIV);
    test_arith("divu0", mduDivu, 32'd9, 32'd0, 32'h12345678, 32'h55AA55AA, LAT_DIV);
  endtask

  task automatic test_illegal();
    logic [31:0] h, l;
    logic [3:0] ops [4] = '{mduNone, mduMfhi, mduMthi, 4'd9};
    foreach (ops[i]) begin
      @(negedge clk);
      Start = 1'b1; HILOCtrl = ops[i]; A = 32'hDEAD; B = 32'd3;
      @(negedge clk);
      Start = 1'b0; HILOCtrl = mduNone;
      total++; if (Busy !== 1'b0) begin bad++; $display("FAIL illegal_busy: op %0d got %b want 0", ops[i], Busy); end
    end
    read_hilo(h, l);
    total++; if (h !== m_hi) begin bad++; $display("FAIL illegal_hi: got %h want %h", h, m_hi); end
    total++; if (l !== m_lo) begin bad++; $display("FAIL illegal_lo: got %h want %h", l, m_lo); end
  endtask

`ifdef MDU_LATENCY_EN
  task automatic test_busy_ignore();
    logic [63:0] e;
    logic [31:0] h, l;
    int n;
    write_hl(mduMthi, 32'h00001111);
    @(negedge clk);
    Start = 1'b1; HILOCtrl = mduMult; A = 32'h00010000; B = 32'h00020003;
    sb.push_back(model(mduMult, 32'h00010000, 32'h00020003));
    @(negedge clk);
    Start = 1'b0; HILOCtrl = mduMfhi; #1;
    total++; if (MDUOut !== 32'h00001111) begin bad++; $display("FAIL pending_hidden: got %h want 00001111", MDUOut); end
    Start = 1'b1; HILOCtrl = mduMthi; A = 32'hDEAD;
    @(negedge clk);
    Start = 1'b1; HILOCtrl = mduDiv; A = 32'd100; B = 32'd7;
    @(negedge clk);
    Start = 1'b0; HILOCtrl = mduMthi; A = 32'hDEAD;
    @(negedge clk);
    HILOCtrl = mduNone;
    n = 3;
    while (Busy === 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    e = sb.pop_front();
    m_hi = e[63:32]; m_lo = e[31:0];
    total++; if (n != LAT_MULT) begin bad++; $display("FAIL ignore_busy: got %0d cycles want %0d", n, LAT_MULT); end
    read_hilo(h, l);
    total++; if (h !== 32'h00000002) begin bad++; $display("FAIL ignore_hi: got %h want 00000002", h); end
    total++; if (l !== 32'h00030000) begin bad++; $display("FAIL ignore_lo: got %h want 00030000", l); end
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL ignore_nolaunch: got %b want 0", Busy); end
  endtask
`else
  task automatic test_busy_ignore();
    logic [31:0] h, l;
    write_hl(mduMthi, 32'h00001111);
    @(negedge clk);
    Start = 1'b1; HILOCtrl = mduMthi; A = 32'hDEAD;
    @(negedge clk);
    Start = 1'b0; HILOCtrl = mduNone;
    read_hilo(h, l);
    total++; if (h !== 32'h00001111) begin bad++; $display("FAIL start_mthi_hi: got %h want 00001111", h); end
    write_hl(mduMthi, 32'h0000DEAD);
    read_hilo(h, l);
    total++; if (h !== 32'h0000DEAD) begin bad++; $display("FAIL mthi2_hi: got %h want 0000dead", h); end
    total++; if (l !== m_lo) begin bad++; $display("FAIL mthi2_lo: got %h want %h", l, m_lo); end
  endtask
`endif

  task automatic test_reset_abort();
    @(negedge clk);
    Start = 1'b1; HILOCtrl = mduMult; A = 32'h12345678; B = 32'h9ABCDEF0;
    sb.push_back(model(mduMult, 32'h12345678, 32'h9ABCDEF0));
    @(negedge clk);
    Start = 1'b0; HILOCtrl = mduMfhi;
    repeat (2) @(negedge clk);
    reset = 1'b1; #1;
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", Busy); end
    total++; if (MDUOut !== 32'd0) begin bad++; $display("FAIL abort_hi: got %h want 0", MDUOut); end
    HILOCtrl = mduMflo; #1;
    total++; if (MDUOut !== 32'd0) begin bad++; $display("FAIL abort_lo: got %h want 0", MDUOut); end
    #1 reset = 1'b0;
    HILOCtrl = mduNone;
    sb.delete();
    m_hi = '0; m_lo = '0;
    test_arith("post_reset_mult", mduMult, 32'd3, 32'd4, 32'd0, 32'd12, LAT_MULT);
  endtask

  task automatic test_back_to_back();
    logic [63:0] e;
    logic [31:0] h, l, a, b;
    logic [3:0] op;
    int n;
    bit to;
    for (int i = 0; i < 8; i++) begin
      op = 4'(1 + $urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      if (op == mduDiv || op == mduDivu) b = b >> $urandom_range(4, 28);
      if (i == 3) begin op = mduDivu; b = 32'd0; end
      if (a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd1;
      run_op(op, a, b, n, to);
      e = sb.pop_front();
      m_hi = e[63:32]; m_lo = e[31:0];
      total++;
      if (to || n != ((op >= mduDiv) ? LAT_DIV : LAT_MULT)) begin
        bad++; $display("FAIL b2b_busy[%0d]: op %0d got %0d cycles", i, op, n);
      end
      read_hilo(h, l);
      total++; if ({h, l} !== e) begin bad++; $display("FAIL b2b_result[%0d]: op %0d a %h b %h got %h%h want %h", i, op, a, b, h, l, e); end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_mthi_mtlo();
    test_arith("mult",  mduMult,  32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE, LAT_MULT);
    test_arith("multu", mduMultu, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, LAT_MULT);
    test_arith("div",   mduDiv,   32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, LAT_DIV);
    test_arith("divu",  mduDivu,  32'd7,        32'd2, 32'd1,        32'd3,        LAT_DIV);
    test_div_zero();
    test_illegal();
    test_busy_ignore();
    test_reset_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
